// File: rtl/state_receiver_pkg.sv
// Shared player-state payload types for the inter-FPGA SPI link.
package state_receiver_pkg;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } location_t;

  // location sits in the low bits so the receiver can slice it straight off the frame
  typedef struct packed {
    logic [3:0] player_id;
    logic [3:0] health;
    location_t  location;
  } data_t;

  localparam int unsigned DATA_W = $bits(data_t);
  localparam int unsigned LOC_W  = $bits(location_t);

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one async line, with edge strobes taken from the
// final stage against its one-cycle-delayed copy.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      last_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~last_q;
  assign fall  = ~level & last_q;

endmodule

// File: rtl/state_receiver.sv
// Receiving end of the player-state SPI link: synchronise, deserialise one frame
// per sel window, strobe good frames out. Optional watchdog: STATE_RECEIVER_TIMEOUT_EN.
module state_receiver
  import state_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 400
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_n_in,
  input  logic                  data_in,
  input  logic                  data_clk_in,
  input  logic                  sel_in,
  output logic [DATA_WIDTH-1:0] player_data_out,
  output logic                  player_data_out_valid,
  output logic [LOC_W-1:0]      location_out,
  output logic                  location_out_valid,
  output logic                  frame_error_out,
  output logic                  busy_out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} rx_state_e;

  logic data_level, data_rise, data_fall;
  logic dclk_level, dclk_rise, dclk_fall;
  logic sel_level, sel_rise, sel_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .async_in(data_in),
    .level(data_level), .rise(data_rise), .fall(data_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dclk (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .async_in(data_clk_in),
    .level(dclk_level), .rise(dclk_rise), .fall(dclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .async_in(sel_in),
    .level(sel_level), .rise(sel_rise), .fall(sel_fall)
  );

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_n;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_n;
  logic                  ovf_q, ovf_d, ovf_n;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [LOC_W-1:0]      loc_d;
  logic                  valid_d, err_d, busy_d;

`ifdef STATE_RECEIVER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            unused_ok;
  assign unused_ok = &{1'b0, data_rise, data_fall, dclk_level, dclk_fall};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, data_rise, data_fall, dclk_level, dclk_fall, TIMEOUT_CYCLES[0]};
`endif

  // State, frame and output registers
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q               <= WAIT_IDLE;
      shift_q               <= '0;
      cnt_q                 <= '0;
      ovf_q                 <= 1'b0;
      settle_q              <= '0;
      player_data_out       <= '0;
      location_out          <= '0;
      player_data_out_valid <= 1'b0;
      location_out_valid    <= 1'b0;
      frame_error_out       <= 1'b0;
      busy_out              <= 1'b0;
`ifdef STATE_RECEIVER_TIMEOUT_EN
      wd_q                  <= '0;
`endif
    end else begin
      state_q               <= state_d;
      shift_q               <= shift_d;
      cnt_q                 <= cnt_d;
      ovf_q                 <= ovf_d;
      settle_q              <= settle_d;
      player_data_out       <= data_d;
      location_out          <= loc_d;
      player_data_out_valid <= valid_d;
      location_out_valid    <= valid_d;
      frame_error_out       <= err_d;
      busy_out              <= busy_d;
`ifdef STATE_RECEIVER_TIMEOUT_EN
      wd_q                  <= wd_d;
`endif
    end
  end

  // Next-state and frame judgement
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    settle_d = settle_q;
    data_d   = player_data_out;
    loc_d    = location_out;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    shift_n  = shift_q;
    cnt_n    = cnt_q;
    ovf_n    = ovf_q;
`ifdef STATE_RECEIVER_TIMEOUT_EN
    wd_d     = wd_q;
`endif

    case (state_q)
      // Wait for the sel chain to hold real pin samples, then for sel idle high
      WAIT_IDLE: begin
        if (settle_q != SET_W'(SYNC_STAGES)) begin
          settle_d = settle_q + SET_W'(1);
        end else if (sel_level) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (sel_fall) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef STATE_RECEIVER_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end

      RECV: begin
        // A bit arriving with the closing sel edge is counted before judging
        if (dclk_rise) begin
          shift_n = {shift_q[DATA_WIDTH-2:0], data_level};
          if (cnt_q == CNT_W'(DATA_WIDTH)) begin
            ovf_n = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        shift_d = shift_n;
        cnt_d   = cnt_n;
        ovf_d   = ovf_n;
`ifdef STATE_RECEIVER_TIMEOUT_EN
        wd_d    = dclk_rise ? '0 : wd_q + WD_W'(1);
`endif
        if (sel_rise) begin
          state_d = IDLE;
          if (cnt_n == CNT_W'(DATA_WIDTH) && !ovf_n) begin
            data_d  = shift_n;
            loc_d   = shift_n[LOC_W-1:0];
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef STATE_RECEIVER_TIMEOUT_EN
        else if (!dclk_rise && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = WAIT_IDLE;
          err_d   = 1'b1;
        end
`endif
      end

      default: state_d = WAIT_IDLE;
    endcase

    busy_d = (state_d == RECV);
  end

endmodule

// File: tb/tb_state_receiver.sv
// Directed bench for state_receiver: table of whole frames plus hand-written
// sequences for reset, back-to-back, coincident edges and the watchdog.
module tb_state_receiver;
  import state_receiver_pkg::*;

  localparam int unsigned W = DATA_W;

  logic          clk_pixel_in = 1'b0;
  logic          rst_n_in;
  logic          data_in;
  logic          data_clk_in;
  logic          sel_in;
  logic [W-1:0]  player_data_out;
  logic          player_data_out_valid;
  logic [LOC_W-1:0] location_out;
  logic          location_out_valid;
  logic          frame_error_out;
  logic          busy_out;

  state_receiver dut (
    .clk_pixel_in(clk_pixel_in),
    .rst_n_in(rst_n_in),
    .data_in(data_in),
    .data_clk_in(data_clk_in),
    .sel_in(sel_in),
    .player_data_out(player_data_out),
    .player_data_out_valid(player_data_out_valid),
    .location_out(location_out),
    .location_out_valid(location_out_valid),
    .frame_error_out(frame_error_out),
    .busy_out(busy_out)
  );

  always #5 clk_pixel_in = ~clk_pixel_in;

  int n_checks = 0;
  int n_fail   = 0;

  int n_valid, n_loc, n_err, n_both, n_loc_mis;
  logic [W-1:0] got_q[$];

  // Strobe monitor, sampled away from the active edge
  always @(negedge clk_pixel_in) begin
    if (player_data_out_valid) begin
      n_valid++;
      got_q.push_back(player_data_out);
    end
    if (location_out_valid) n_loc++;
    if (frame_error_out) n_err++;
    if (player_data_out_valid && frame_error_out) n_both++;
    if (player_data_out_valid != location_out_valid) n_loc_mis++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pixel_in);
  endtask

  task automatic clear_counts();
    n_valid = 0; n_loc = 0; n_err = 0;
    got_q.delete();
  endtask

  // MSB first, 2 clk data setup, 3 clk high, 2 clk low
  task automatic send_bits(input logic [39:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = bits[i];
      tick(2);
      data_clk_in = 1'b1;
      tick(3);
      data_clk_in = 1'b0;
      tick(2);
    end
  endtask

  task automatic send_frame(input logic [39:0] bits, input int n);
    sel_in = 1'b0;
    tick(2);
    send_bits(bits, n);
    sel_in = 1'b1;
    tick(10);
  endtask

  typedef struct {
    logic [39:0] bits;
    int          nbits;
    int          exp_valid;
    int          exp_err;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{40'hA5A5A5A5,   32, 1, 0, 32'hA5A5A5A5};
    vecs[1] = '{40'h12345678,   31, 0, 1, 32'hA5A5A5A5};
    vecs[2] = '{40'h1A5A5A5A5,  33, 0, 1, 32'hA5A5A5A5};
    vecs[3] = '{40'h12345678,   32, 1, 0, 32'h12345678};
    vecs[4] = '{40'h0,           0, 0, 1, 32'h12345678};
    vecs[5] = '{40'hFFFFFFFF,   32, 1, 0, 32'hFFFFFFFF};
    vecs[6] = '{40'h00000000,   32, 1, 0, 32'h00000000};
    vecs[7] = '{40'hDEADBEEF,   32, 1, 0, 32'hDEADBEEF};

    n_both = 0; n_loc_mis = 0;
    clear_counts();
    rst_n_in = 1'b0; data_in = 1'b0; data_clk_in = 1'b0; sel_in = 1'b1;
    tick(3);
    check("reset_data", 64'(player_data_out), 64'h0);
    check("reset_loc", 64'(location_out), 64'h0);
    check("reset_strobes", 64'({player_data_out_valid, location_out_valid, frame_error_out}), 64'h0);
    check("reset_busy", 64'(busy_out), 64'h0);
    rst_n_in = 1'b1;
    tick(8);
    check("idle_no_strobe", 64'(n_valid + n_err), 64'h0);

    // Table of whole frames
    for (int v = 0; v < 8; v++) begin
      clear_counts();
      send_frame(vecs[v].bits, vecs[v].nbits);
      check($sformatf("vec%0d_valid", v), 64'(n_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d_err", v), 64'(n_err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_data", v), 64'(player_data_out), 64'(vecs[v].exp_data));
      check($sformatf("vec%0d_loc", v), 64'(location_out), 64'(vecs[v].exp_data[LOC_W-1:0]));
      check($sformatf("vec%0d_busy", v), 64'(busy_out), 64'h0);
    end

    // Busy while receiving
    clear_counts();
    sel_in = 1'b0;
    tick(2);
    send_bits(40'h3, 2);
    check("busy_in_recv", 64'(busy_out), 64'h1);
    send_bits(40'h0, 30);
    sel_in = 1'b1;
    tick(10);
    check("busy_frame_valid", 64'(n_valid), 64'h1);
    check("busy_frame_data", 64'(player_data_out), 64'hC0000000);

    // Reset mid-frame, released with sel still low
    clear_counts();
    sel_in = 1'b0;
    tick(2);
    send_bits(40'hCAFEF00D >> 22, 10);
    rst_n_in = 1'b0;
    tick(3);
    check("midrst_data_zero", 64'(player_data_out), 64'h0);
    rst_n_in = 1'b1;
    tick(2);
    send_bits(40'hCAFEF00D, 22);
    sel_in = 1'b1;
    tick(10);
    check("midrst_no_valid", 64'(n_valid), 64'h0);
    check("midrst_no_err", 64'(n_err), 64'h0);
    send_frame(40'hCAFEF00D, 32);
    check("midrst_next_valid", 64'(n_valid), 64'h1);
    check("midrst_next_data", 64'(player_data_out), 64'hCAFEF00D);

    // Back-to-back frames, one clk of sel high between them
    clear_counts();
    sel_in = 1'b0;
    tick(2);
    send_bits(40'h11111111, 32);
    sel_in = 1'b1;
    tick(1);
    sel_in = 1'b0;
    tick(2);
    send_bits(40'h87654321, 32);
    sel_in = 1'b1;
    tick(10);
    check("b2b_valid_count", 64'(n_valid), 64'h2);
    check("b2b_err", 64'(n_err), 64'h0);
    if (got_q.size() == 2) begin
      check("b2b_first", 64'(got_q[0]), 64'h11111111);
      check("b2b_second", 64'(got_q[1]), 64'h87654321);
    end else begin
      check("b2b_strobe_queue", 64'(got_q.size()), 64'h2);
    end
    check("b2b_loc", 64'(location_out), 64'h654321);

    // Final data_clk rise coincides with sel rise
    clear_counts();
    sel_in = 1'b0;
    tick(2);
    send_bits(40'h5A5A5A5B >> 1, 31);
    data_in = 1'b1;
    tick(2);
    data_clk_in = 1'b1;
    sel_in = 1'b1;
    tick(3);
    data_clk_in = 1'b0;
    tick(10);
    check("coinc_valid", 64'(n_valid), 64'h1);
    check("coinc_err", 64'(n_err), 64'h0);
    check("coinc_data", 64'(player_data_out), 64'h5A5A5A5B);

    // Stalled data_clk after 5 bits
    clear_counts();
    sel_in = 1'b0;
    tick(2);
    send_bits(40'h1F, 5);
    tick(450);
`ifdef STATE_RECEIVER_TIMEOUT_EN
    check("stall_err", 64'(n_err), 64'h1);
    check("stall_busy", 64'(busy_out), 64'h0);
`else
    check("stall_err", 64'(n_err), 64'h0);
    check("stall_busy", 64'(busy_out), 64'h1);
`endif
    check("stall_no_valid", 64'(n_valid), 64'h0);
    sel_in = 1'b1;
    tick(10);
    check("stall_close_err", 64'(n_err), 64'h1);
    check("stall_close_busy", 64'(busy_out), 64'h0);
    check("stall_data_kept", 64'(player_data_out), 64'h5A5A5A5B);
    send_frame(40'h0F0F1234, 32);
    check("stall_recover_valid", 64'(n_valid), 64'h1);
    check("stall_recover_data", 64'(player_data_out), 64'h0F0F1234);

    check("never_valid_and_err", 64'(n_both), 64'h0);
    check("loc_valid_coincident", 64'(n_loc_mis), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
